mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_if.sv | 22 ++
 rtl/mem_responder.sv | 150 +++++++++++++++
 tb/tb_mem_responder.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bundle between a memory requester and mem_responder.
interface mem_responder_if;
  logic        req_in;
  logic [31:0] addr_in;
  logic        rw_in;
  logic [1:0]  access_size_in;
  logic [31:0] data_in;
  logic        busy_out;
  logic [31:0] data_out;
  logic        valid_out;
  logic        err_out;

  modport slave (
    input  req_in, addr_in, rw_in, access_size_in, data_in,
    output busy_out, data_out, valid_out, err_out
  );

  modport master (
    output req_in, addr_in, rw_in, access_size_in, data_in,
    input  busy_out, data_out, valid_out, err_out
  );
endinterface

// File: rtl/mem_responder.sv
// Word-organised, big-endian memory answering byte/halfword/word accesses
// and aligned 4-word bursts.
//
// state       | meaning
// ST_IDLE     | accepting requests; single accesses complete here
// ST_BURST_RD | returning burst words 1..3
// ST_BURST_WR | writing burst words 1..3 from data_in
module mem_responder #(
  parameter int MEM_WORDS = 256
) (
  input logic            clk_in,
  input logic            reset_n_in,
  mem_responder_if.slave bus
);
  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BURST_RD = 2'd1,
    ST_BURST_WR = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_beat, w_beat_nxt;
  logic [AW-1:0]   r_burst_idx, w_burst_idx_nxt;
  logic [31:0]     r_data, w_data_nxt;
  logic            r_valid, w_valid_nxt;
  logic            r_err, w_err_nxt;
  logic [31:0]     r_mem [MEM_WORDS];

  logic            w_accept;
  logic            w_bad;
  logic [1:0]      w_off;
  logic [AW-1:0]   w_req_idx;
  logic            w_mem_we;
  logic [3:0]      w_mem_be;
  logic [31:0]     w_mem_wdata;
  logic [AW-1:0]   w_mem_idx;
  logic [31:0]     w_rd_word;

  assign bus.busy_out  = (r_state != ST_IDLE);
  assign bus.data_out  = r_data;
  assign bus.valid_out = r_valid;
  assign bus.err_out   = r_err;

  assign w_accept  = reset_n_in && bus.req_in && (r_state == ST_IDLE);
  assign w_off     = bus.addr_in[1:0];
  assign w_req_idx = bus.addr_in[AW+1:2];
  assign w_rd_word = r_mem[w_mem_idx];

  always_comb begin
    w_bad = (bus.addr_in[31:AW+2] != '0);
    case (bus.access_size_in)
      2'b01:   if (bus.addr_in[0])          w_bad = 1'b1;
      2'b10:   if (bus.addr_in[1:0] != '0)  w_bad = 1'b1;
      2'b11:   if (bus.addr_in[3:0] != '0)  w_bad = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_beat_nxt      = r_beat;
    w_burst_idx_nxt = r_burst_idx;
    w_data_nxt      = r_data;
    w_valid_nxt     = 1'b0;
    w_err_nxt       = 1'b0;
    w_mem_we        = 1'b0;
    w_mem_be        = 4'hF;
    w_mem_wdata     = bus.data_in;
    w_mem_idx       = w_req_idx;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_bad) begin
            w_err_nxt = 1'b1;
          end else begin
            w_valid_nxt = 1'b1;
            if (bus.rw_in) begin
              w_mem_we = 1'b1;
              case (bus.access_size_in)
                2'b00: begin
                  w_mem_be    = 4'b1000 >> w_off;
                  w_mem_wdata = {4{bus.data_in[7:0]}};
                end
                2'b01: begin
                  w_mem_be    = w_off[1] ? 4'b0011 : 4'b1100;
                  w_mem_wdata = {2{bus.data_in[15:0]}};
                end
                default: ;
              endcase
            end else begin
              // byte 0 sits in the most significant lane
              case (bus.access_size_in)
                2'b00:   w_data_nxt = {24'h0, w_rd_word[{~w_off, 3'b000} +: 8]};
                2'b01:   w_data_nxt = {16'h0, w_rd_word[{~w_off[1], 4'b0000} +: 16]};
                default: w_data_nxt = w_rd_word;
              endcase
            end
            if (bus.access_size_in == 2'b11) begin
              w_state_nxt     = bus.rw_in ? ST_BURST_WR : ST_BURST_RD;
              w_beat_nxt      = 3'd1;
              w_burst_idx_nxt = w_req_idx + 1'b1;
            end
          end
        end
      end
      ST_BURST_RD, ST_BURST_WR: begin
        w_mem_idx       = r_burst_idx;
        w_valid_nxt     = 1'b1;
        w_burst_idx_nxt = r_burst_idx + 1'b1;
        w_beat_nxt      = r_beat + 3'd1;
        if (r_state == ST_BURST_WR) w_mem_we   = 1'b1;
        else                        w_data_nxt = w_rd_word;
        if (r_beat == 3'd3) begin
          w_state_nxt = ST_IDLE;
          w_beat_nxt  = 3'd0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      r_state     <= ST_IDLE;
      r_beat      <= 3'd0;
      r_burst_idx <= '0;
      r_data      <= 32'h0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_beat      <= w_beat_nxt;
      r_burst_idx <= w_burst_idx_nxt;
      r_data      <= w_data_nxt;
      r_valid     <= w_valid_nxt;
      r_err       <= w_err_nxt;
    end
  end

  // Contents survive reset; a reset cycle only suppresses the write.
  always_ff @(posedge clk_in) begin
    if (reset_n_in && w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_mem_be[i]) r_mem[w_mem_idx][8*i +: 8] <= w_mem_wdata[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: byte-addressed reference memory with burst timing
// tracked by cycle numbers, plus directed literal expectations.
module tb_mem_responder;
  localparam int MW = 256;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if bus();

  mem_responder #(.MEM_WORDS(MW)) dut (
    .clk_in     (clk),
    .reset_n_in (reset_n),
    .bus        (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  mb [4*MW];
  int          cyc = 0;
  int          burst_n = -100;
  int          burst_a = 0;
  bit          burst_rw = 1'b0;
  logic [31:0] burst_words [4];
  int          k_m;
  int          a_m;
  bit          mdl_live = 1'b0;
  logic        e_busy, e_valid, e_err, e_chk;
  logic [31:0] e_data;

  initial for (int i = 0; i < 4*MW; i++) mb[i] = 8'h00;

  function automatic logic [31:0] rd_word(input int a);
    return {mb[a], mb[a+1], mb[a+2], mb[a+3]};
  endfunction

  function automatic bit is_bad(input logic [31:0] a, input logic [1:0] sz);
    return (a >= 32'(4*MW)) || (sz == 2'd1 && a[0]) ||
           (sz == 2'd2 && a[1:0] != 2'd0) || (sz == 2'd3 && a[3:0] != 4'd0);
  endfunction

  task automatic wr_word(input int a, input logic [31:0] d);
    mb[a] = d[31:24]; mb[a+1] = d[23:16]; mb[a+2] = d[15:8]; mb[a+3] = d[7:0];
  endtask

  always @(posedge clk) begin
    cyc++;
    mdl_live = 1'b1;
    e_valid = 1'b0;
    e_err   = 1'b0;
    e_chk   = 1'b0;
    if (!reset_n) begin
      burst_n = -100;
      e_busy  = 1'b0;
      e_chk   = 1'b1;
      e_data  = 32'h0;
    end else begin
      k_m = cyc - burst_n;
      if (k_m >= 1 && k_m <= 3) begin
        e_valid = 1'b1;
        if (burst_rw) wr_word(burst_a + 4*k_m, bus.data_in);
        else begin
          e_chk  = 1'b1;
          e_data = burst_words[k_m];
        end
      end else if (bus.req_in) begin
        if (is_bad(bus.addr_in, bus.access_size_in)) begin
          e_err = 1'b1;
        end else begin
          a_m = int'(bus.addr_in);
          e_valid = 1'b1;
          e_chk   = !bus.rw_in;
          case (bus.access_size_in)
            2'd0: if (bus.rw_in) mb[a_m] = bus.data_in[7:0];
                  else e_data = {24'h0, mb[a_m]};
            2'd1: if (bus.rw_in) {mb[a_m], mb[a_m+1]} = bus.data_in[15:0];
                  else e_data = {16'h0, mb[a_m], mb[a_m+1]};
            2'd2: if (bus.rw_in) wr_word(a_m, bus.data_in);
                  else e_data = rd_word(a_m);
            default: begin
              burst_n  = cyc;
              burst_rw = bus.rw_in;
              burst_a  = a_m;
              if (bus.rw_in) wr_word(a_m, bus.data_in);
              else begin
                for (int j = 0; j < 4; j++) burst_words[j] = rd_word(a_m + 4*j);
                e_data = burst_words[0];
              end
            end
          endcase
        end
      end
      e_busy = (cyc - burst_n) >= 0 && (cyc - burst_n) < 3;
    end
  end

  always @(negedge clk) begin
    if (mdl_live) begin
      chk1("busy_out", bus.busy_out, e_busy);
      chk1("valid_out", bus.valid_out, e_valid);
      chk1("err_out", bus.err_out, e_err);
      if (e_chk) chk32("data_out", bus.data_out, e_data);
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic rw, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    bus.req_in = 1'b1; bus.rw_in = rw; bus.access_size_in = sz;
    bus.addr_in = a; bus.data_in = d;
    @(posedge clk); #1;
    bus.req_in = 1'b0;
  endtask

  task automatic burst_wr(input logic [31:0] a, input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3, input bit chk_busy);
    issue(1'b1, 2'd3, a, d0);
    if (chk_busy) chk1("bwr_busy_first", bus.busy_out, 1'b1);
    bus.data_in = d1; @(posedge clk); #1;
    bus.data_in = d2; @(posedge clk); #1;
    bus.data_in = d3; @(posedge clk); #1;
    if (chk_busy) chk1("bwr_busy_end", bus.busy_out, 1'b0);
  endtask

  function automatic logic [31:0] gen_addr(input logic [1:0] sz);
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0:       a = $urandom;
      1:       a = $urandom_range(4*MW, 4*MW + 63);
      2, 3, 4: a = $urandom_range(0, 63);
      default: a = $urandom_range(0, 4*MW - 1);
    endcase
    if ($urandom_range(0, 4) != 0) begin
      case (sz)
        2'd1:    a[0]   = 1'b0;
        2'd2:    a[1:0] = 2'b00;
        2'd3:    a[3:0] = 4'h0;
        default: ;
      endcase
    end
    return a;
  endfunction

  initial begin
    bus.req_in = 1'b1; bus.rw_in = 1'b1; bus.access_size_in = 2'd2;
    bus.addr_in = 32'h0; bus.data_in = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_busy", bus.busy_out, 1'b0);
    chk1("rst_valid", bus.valid_out, 1'b0);
    chk1("rst_err", bus.err_out, 1'b0);
    chk32("rst_data", bus.data_out, 32'h0);
    bus.req_in = 1'b0;
    reset_n = 1'b1;

    for (int w = 0; w < MW; w += 4)
      burst_wr(32'(4*w), $urandom, $urandom, $urandom, $urandom, 1'b0);

    issue(1'b1, 2'd2, 32'h10, 32'hDEADBEEF);
    chk1("wr_word_valid", bus.valid_out, 1'b1);
    issue(1'b0, 2'd2, 32'h10, 32'h0);
    chk1("rd_word_valid", bus.valid_out, 1'b1);
    chk32("rd_word_10", bus.data_out, 32'hDEADBEEF);
    issue(1'b1, 2'd0, 32'h11, 32'h0000_0055);
    issue(1'b0, 2'd2, 32'h10, 32'h0);
    chk32("rd_after_byte", bus.data_out, 32'hDE55BEEF);
    issue(1'b0, 2'd1, 32'h12, 32'h0);
    chk32("rd_half_12", bus.data_out, 32'h0000BEEF);
    issue(1'b0, 2'd0, 32'h11, 32'h0);
    chk32("rd_byte_11", bus.data_out, 32'h0000_0055);

    burst_wr(32'h20, 32'd1, 32'd2, 32'd3, 32'd4, 1'b1);
    issue(1'b0, 2'd3, 32'h20, 32'h0);
    chk32("brd_beat0", bus.data_out, 32'd1);
    chk1("brd_busy0", bus.busy_out, 1'b1);
    for (int b = 1; b < 4; b++) begin
      @(posedge clk); #1;
      chk32("brd_beat", bus.data_out, 32'(b + 1));
      chk1("brd_valid", bus.valid_out, 1'b1);
      chk1("brd_busy", bus.busy_out, b < 3);
    end

    issue(1'b0, 2'd2, 32'h02, 32'h0);
    chk1("err_word_mis", bus.err_out, 1'b1);
    chk1("err_word_novalid", bus.valid_out, 1'b0);
    issue(1'b0, 2'd1, 32'h01, 32'h0);
    chk1("err_half_mis", bus.err_out, 1'b1);
    issue(1'b0, 2'd3, 32'h24, 32'h0);
    chk1("err_burst_mis", bus.err_out, 1'b1);
    chk1("err_burst_nobusy", bus.busy_out, 1'b0);
    issue(1'b1, 2'd2, 32'h400, 32'h1234_5678);
    chk1("err_range", bus.err_out, 1'b1);
    issue(1'b0, 2'd2, 32'h24, 32'h0);
    chk32("err_mem_intact", bus.data_out, 32'd2);

    burst_wr(32'h40, 32'hAAAA0000, 32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003, 1'b0);
    issue(1'b1, 2'd3, 32'h40, 32'hBBBB0000);
    bus.data_in = 32'hBBBB0001;
    @(posedge clk); #1;
    reset_n = 1'b0;
    bus.data_in = 32'hBBBB0002;
    @(posedge clk); #1;
    chk1("midrst_busy", bus.busy_out, 1'b0);
    chk1("midrst_valid", bus.valid_out, 1'b0);
    chk32("midrst_data", bus.data_out, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    issue(1'b0, 2'd2, 32'h40, 32'h0);
    chk1("post_rst_accept", bus.valid_out, 1'b1);
    chk32("midrst_w40", bus.data_out, 32'hBBBB0000);
    issue(1'b0, 2'd2, 32'h44, 32'h0);
    chk32("midrst_w44", bus.data_out, 32'hBBBB0001);
    issue(1'b0, 2'd2, 32'h48, 32'h0);
    chk32("midrst_w48", bus.data_out, 32'hAAAA0002);
    issue(1'b0, 2'd2, 32'h4C, 32'h0);
    chk32("midrst_w4c", bus.data_out, 32'hAAAA0003);

    issue(1'b1, 2'd2, 32'h80, 32'h1234_5678);
    bus.req_in = 1'b1; bus.rw_in = 1'b0; bus.access_size_in = 2'd3;
    bus.addr_in = 32'h20;
    @(posedge clk); #1;
    bus.access_size_in = 2'd2; bus.addr_in = 32'h80;
    chk32("hold_beat0", bus.data_out, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk32("hold_beat3", bus.data_out, 32'd4);
    chk1("hold_busy_low", bus.busy_out, 1'b0);
    @(posedge clk); #1;
    bus.req_in = 1'b0;
    chk1("hold_accept_valid", bus.valid_out, 1'b1);
    chk32("hold_accept_data", bus.data_out, 32'h1234_5678);

    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(0, 199) != 0);
      bus.req_in = ($urandom_range(0, 3) != 0);
      bus.rw_in = 1'($urandom_range(0, 1));
      bus.access_size_in = 2'($urandom_range(0, 3));
      bus.addr_in = gen_addr(bus.access_size_in);
      bus.data_in = $urandom;
      @(posedge clk); #1;
    end
    reset_n = 1'b1;
    bus.req_in = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
